// File: rtl/pkt_ingress_framer.sv
// Store-and-forward framer: buffers whole AXI-Stream packets, replays them as tagged 134-bit bursts.
// Latency: tail beat accepted in cycle T gives the first egress word in T+3 when the reader is idle.
// Backpressure: s_axis_tready drops only while the descriptor FIFO is full; egress never stalls.
module pkt_ingress_framer #(
  parameter int DATA_DEPTH    = 512,
  parameter int DESC_DEPTH    = 32,
  parameter int MAX_PKT_WORDS = 128
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [127:0] s_axis_tdata,
  input  logic [15:0]  s_axis_tkeep,
  input  logic         s_axis_tlast,
  input  logic [7:0]   i_inport,
  output logic         o_pkt_valid,
  output logic [133:0] o_pkt,
  output logic [7:0]   o_inport,
  output logic [31:0]  o_pkt_cnt,
  output logic [31:0]  o_drop_cnt
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = $clog2(DESC_DEPTH);
  localparam int QW = DW + 1;
  localparam int LW = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [PW-1:0] DATA_FULL = PW'(DATA_DEPTH);
  localparam logic [QW-1:0] DESC_FULL = QW'(DESC_DEPTH);
  localparam logic [LW-1:0] MAX_LEN   = LW'(MAX_PKT_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_BURST, R_GAP} rd_state_t;

  // Empty-byte count of a legal last beat: the zeros below the run of ones, never more than 15.
  function automatic logic [3:0] ones15(input logic [14:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 15; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  logic [127:0]  mem [DATA_DEPTH];
  logic [7:0]    desc_port [DESC_DEPTH];
  logic [LW-1:0] desc_len  [DESC_DEPTH];
  logic [3:0]    desc_pad  [DESC_DEPTH];

  wr_state_t     wr_state, wr_next;
  rd_state_t     rd_state, rd_next;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [QW-1:0] desc_wp, desc_rp;
  logic [LW-1:0] wr_cnt, rd_rem;
  logic [7:0]    pkt_inport, rd_port;
  logic [3:0]    rd_pad, pad_q;
  logic [1:0]    tag_q;
  logic [127:0]  rd_dat;
  logic          rd_first;
  logic [15:0]   keep_inv;
  logic          keep_ok, buf_full, desc_empty, accept;
  logic          wr_en, drop, commit, rd_pop, rd_en, pkt_done;

  assign keep_inv      = ~s_axis_tkeep;
  assign keep_ok       = s_axis_tlast ? ((s_axis_tkeep != 16'd0) && ((keep_inv & (keep_inv + 16'd1)) == 16'd0))
                                      : (s_axis_tkeep == 16'hFFFF);
  assign buf_full      = (wr_ptr - rd_ptr) == DATA_FULL;
  assign desc_empty    = desc_wp == desc_rp;
  assign s_axis_tready = (desc_wp - desc_rp) != DESC_FULL;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign o_pkt         = o_pkt_valid ? {tag_q, pad_q, rd_dat} : 134'd0;

  // Write FSM decode: buffer a legal beat, commit on tail, or drop the whole packet.
  always_comb begin
    wr_next = wr_state;
    wr_en   = 1'b0;
    drop    = 1'b0;
    commit  = 1'b0;
    unique case (wr_state)
      W_IDLE: if (accept) begin
        if (!keep_ok || buf_full || s_axis_tlast) begin
          drop    = 1'b1;
          wr_next = s_axis_tlast ? W_IDLE : W_DROP;
        end else begin
          wr_en   = 1'b1;
          wr_next = W_WRITE;
        end
      end
      W_WRITE: if (accept) begin
        if (!keep_ok || buf_full || wr_cnt == MAX_LEN) begin
          drop    = 1'b1;
          wr_next = s_axis_tlast ? W_IDLE : W_DROP;
        end else begin
          wr_en = 1'b1;
          if (s_axis_tlast) begin
            commit  = 1'b1;
            wr_next = W_IDLE;
          end
        end
      end
      W_DROP: if (accept && s_axis_tlast) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Write-side state, pointers and drop counter; a drop rewinds to the last committed packet.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_state   <= W_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      wr_cnt     <= '0;
      pkt_inport <= '0;
      desc_wp    <= '0;
      o_drop_cnt <= '0;
    end else begin
      wr_state <= wr_next;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        wr_cnt <= (wr_state == W_IDLE) ? LW'(1) : wr_cnt + LW'(1);
        if (wr_state == W_IDLE) pkt_inport <= i_inport;
      end
      if (commit) begin
        commit_ptr <= wr_ptr + PW'(1);
        desc_wp    <= desc_wp + QW'(1);
      end
      if (drop) begin
        wr_ptr     <= commit_ptr;
        o_drop_cnt <= o_drop_cnt + 32'd1;
      end
    end
  end

  // Storage writes: packet data and the descriptor pushed on commit.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
    if (commit) begin
      desc_port[desc_wp[DW-1:0]] <= pkt_inport;
      desc_len[desc_wp[DW-1:0]]  <= wr_cnt + LW'(1);
      desc_pad[desc_wp[DW-1:0]]  <= ones15(keep_inv[14:0]);
    end
  end

  // Read FSM decode: GAP also pops so back-to-back packets see a single idle cycle.
  always_comb begin
    rd_next  = rd_state;
    rd_pop   = 1'b0;
    rd_en    = 1'b0;
    pkt_done = 1'b0;
    unique case (rd_state)
      R_IDLE: if (!desc_empty) begin
        rd_pop  = 1'b1;
        rd_next = R_BURST;
      end
      R_BURST: begin
        rd_en = 1'b1;
        if (rd_rem == LW'(1)) rd_next = R_GAP;
      end
      R_GAP: begin
        pkt_done = 1'b1;
        if (!desc_empty) begin
          rd_pop  = 1'b1;
          rd_next = R_BURST;
        end else begin
          rd_next = R_IDLE;
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Read-side state and registered egress tag/port, aligned with the one-cycle memory read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_state    <= R_IDLE;
      rd_ptr      <= '0;
      desc_rp     <= '0;
      rd_rem      <= '0;
      rd_first    <= 1'b0;
      rd_port     <= '0;
      rd_pad      <= '0;
      tag_q       <= '0;
      pad_q       <= '0;
      o_inport    <= '0;
      o_pkt_valid <= 1'b0;
      o_pkt_cnt   <= '0;
    end else begin
      rd_state    <= rd_next;
      o_pkt_valid <= rd_en;
      if (rd_pop) begin
        rd_rem   <= desc_len[desc_rp[DW-1:0]];
        rd_port  <= desc_port[desc_rp[DW-1:0]];
        rd_pad   <= desc_pad[desc_rp[DW-1:0]];
        rd_first <= 1'b1;
        desc_rp  <= desc_rp + QW'(1);
      end
      if (rd_en) begin
        rd_rem   <= rd_rem - LW'(1);
        rd_first <= 1'b0;
        rd_ptr   <= rd_ptr + PW'(1);
        o_inport <= rd_port;
        tag_q    <= rd_first ? 2'b01 : ((rd_rem == LW'(1)) ? 2'b10 : 2'b11);
        pad_q    <= (rd_rem == LW'(1)) ? rd_pad : 4'd0;
      end
      if (pkt_done) o_pkt_cnt <= o_pkt_cnt + 32'd1;
    end
  end

  // Buffer read port; the data register needs no reset because o_pkt is masked when invalid.
  always_ff @(posedge i_clk) begin
    if (rd_en) rd_dat <= mem[rd_ptr[AW-1:0]];
  end

endmodule
